// File: rtl/int_seq.sv
// Interrupt entry/exit sequencer: takes one request, redirects fetch to VEC_ADDR at a boundary, returns on RETI.
// Registered outputs, redirect 2 cycles after accept; int_rdy low from accept until the cycle after the return redirect.
module int_seq #(
  parameter int              DW       = 16,
  parameter int              AW       = 13,
  parameter logic [AW-1:0]   VEC_ADDR = 13'h0004,
  parameter logic [11:0]     EPC_A    = 12'h4,
  parameter logic [11:0]     ISTA_A   = 12'h5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          int_vld,
  output logic          int_rdy,
  input  logic          ibnd,
  input  logic          reti,
  input  logic [AW-1:0] pc_cur,
  input  logic [3:0]    flg_i,
  output logic          redirect,
  output logic [AW-1:0] redirect_pc,
  output logic          stall,
  output logic [3:0]    flg_o,
  output logic          flg_we,
  output logic          in_isr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr,
  input  logic          we,
  output logic [DW-1:0] dout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_ENTER = 3'd2,
    S_ISR   = 3'd3,
    S_RET   = 3'd4
  } state_t;

  localparam logic [AW-1:0] EPC_ADR  = AW'(EPC_A);
  localparam logic [AW-1:0] ISTA_ADR = AW'(ISTA_A);

  state_t        state_q, state_d;
  logic [AW-1:0] epc_q, epc_d;
  logic [3:0]    eflg_q, eflg_d;
  logic          int_rdy_q, int_rdy_d;
  logic          redirect_q, redirect_d;
  logic [AW-1:0] redirect_pc_q, redirect_pc_d;
  logic          stall_q, stall_d;
  logic [3:0]    flg_o_q, flg_o_d;
  logic          flg_we_q, flg_we_d;
  logic          in_isr_q, in_isr_d;
  logic [DW-1:0] dout_q, dout_d;

  // EPC holds only AW bits; the rest of the write data is discarded
  logic unused_din;
  assign unused_din = ^din[DW-1:AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      epc_q         <= '0;
      eflg_q        <= '0;
      int_rdy_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      stall_q       <= 1'b0;
      flg_o_q       <= '0;
      flg_we_q      <= 1'b0;
      in_isr_q      <= 1'b0;
      dout_q        <= '0;
    end else begin
      state_q       <= state_d;
      epc_q         <= epc_d;
      eflg_q        <= eflg_d;
      int_rdy_q     <= int_rdy_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      stall_q       <= stall_d;
      flg_o_q       <= flg_o_d;
      flg_we_q      <= flg_we_d;
      in_isr_q      <= in_isr_d;
      dout_q        <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    eflg_d  = eflg_q;
    if (we && (addr == EPC_ADR)) epc_d = din[AW-1:0];
    case (state_q)
      S_IDLE:  if (int_vld && int_rdy_q) state_d = S_PEND;
      S_PEND: begin
        // boundary capture takes priority over a coincident bus write
        if (ibnd) begin
          epc_d   = pc_cur;
          eflg_d  = flg_i;
          state_d = S_ENTER;
        end
      end
      S_ENTER: state_d = S_ISR;
      S_ISR:   if (ibnd && reti) state_d = S_RET;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs follow the next state so they appear registered in the same cycle as the state
  always_comb begin
    int_rdy_d     = (state_d == S_IDLE);
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    stall_d       = 1'b0;
    flg_o_d       = '0;
    flg_we_d      = 1'b0;
    in_isr_d      = 1'b0;
    case (state_d)
      S_ENTER: begin
        redirect_d    = 1'b1;
        redirect_pc_d = VEC_ADDR;
        stall_d       = 1'b1;
      end
      S_ISR: in_isr_d = 1'b1;
      S_RET: begin
        redirect_d    = 1'b1;
        redirect_pc_d = epc_q;
        flg_o_d       = eflg_q;
        flg_we_d      = 1'b1;
        stall_d       = 1'b1;
        in_isr_d      = 1'b1;
      end
      default: ;
    endcase

    dout_d = dout_q;
    if (!we) begin
      if (addr == EPC_ADR)       dout_d = {{(DW-AW){1'b0}}, epc_q};
      else if (addr == ISTA_ADR) dout_d = {{(DW-8){1'b0}}, eflg_q, state_q, in_isr_q};
      else                       dout_d = '0;
    end
  end

  assign int_rdy     = int_rdy_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign stall       = stall_q;
  assign flg_o       = flg_o_q;
  assign flg_we      = flg_we_q;
  assign in_isr      = in_isr_q;
  assign dout        = dout_q;

endmodule

// File: tb/tb_int_seq.sv
// Bench for int_seq: directed and random interrupt entries/returns, redirects and bus reads
// are predicted into queues and popped by a monitor on the falling edge.
module tb_int_seq;
  localparam int DW = 16;
  localparam int AW = 13;
  localparam logic [AW-1:0] VEC     = 13'h0004;
  localparam logic [AW-1:0] EPC_AD  = 13'h0004;
  localparam logic [AW-1:0] ISTA_AD = 13'h0005;
  localparam logic [AW-1:0] PARK    = 13'h1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          int_vld = 1'b0;
  logic          int_rdy;
  logic          ibnd = 1'b0;
  logic          reti = 1'b0;
  logic [AW-1:0] pc_cur = '0;
  logic [3:0]    flg_i = '0;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          stall;
  logic [3:0]    flg_o;
  logic          flg_we;
  logic          in_isr;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] addr = 13'h1000;
  logic          we = 1'b0;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  int_seq dut (
    .clk(clk), .rst(rst), .int_vld(int_vld), .int_rdy(int_rdy),
    .ibnd(ibnd), .reti(reti), .pc_cur(pc_cur), .flg_i(flg_i),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .flg_o(flg_o), .flg_we(flg_we), .in_isr(in_isr),
    .din(din), .addr(addr), .we(we), .dout(dout)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          fwe;
    logic [3:0]    fo;
  } redir_t;

  redir_t        exp_redir[$];
  logic [DW-1:0] exp_rd[$];
  redir_t        mon_r;
  int            errors = 0;
  int            checks = 0;
  logic          rd_req = 1'b0;
  logic          rd_seen;
  logic [AW-1:0] m_epc = '0;
  logic [3:0]    m_eflg = '0;

  always @(posedge clk or negedge rst)
    if (!rst) rd_seen <= 1'b0;
    else      rd_seen <= rd_req;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (redirect) begin
        if (exp_redir.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_redirect: got pc %0h expected no redirect at %0t", redirect_pc, $time);
        end else begin
          mon_r = exp_redir.pop_front();
          check("redirect_pc", redirect_pc, mon_r.pc);
          check("redirect_flg_we", flg_we, mon_r.fwe);
          check("redirect_flg_o", flg_o, mon_r.fo);
        end
      end else if (flg_we) begin
        checks++; errors++;
        $display("FAIL stray_flg_we: got 1 expected 0 at %0t", $time);
      end
      if (rd_seen) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL dout_no_expect: got %0h expected nothing at %0t", dout, $time);
        end else check("dout", dout, exp_rd.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_bus();
    ibnd = 1'b0; reti = 1'b0; we = 1'b0; addr = PARK; rd_req = 1'b0;
  endtask

  function automatic logic [DW-1:0] ista(input logic [2:0] code, input logic isr);
    return {8'h00, m_eflg, code, isr};
  endfunction

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    we = 1'b0; addr = a; rd_req = 1'b1; exp_rd.push_back(e);
    step(); clear_bus();
  endtask

  task automatic wr_epc(input logic [DW-1:0] v);
    we = 1'b1; addr = EPC_AD; din = v; m_epc = v[AW-1:0];
    step(); clear_bus();
  endtask

  // ends in the ENTER cycle
  task automatic do_entry(input logic [AW-1:0] pc, input logic [3:0] fl, input int delay,
                          input logic hold, input logic push);
    logic [DW-1:0] v;
    check("int_rdy_idle", int_rdy, 1);
    int_vld = 1'b1;
    if (push) exp_redir.push_back('{pc: VEC, fwe: 1'b0, fo: 4'h0});
    step();
    if (!hold) int_vld = 1'b0;
    check("int_rdy_pend", int_rdy, 0);
    check("in_isr_pend", in_isr, 0);
    for (int i = 0; i < delay; i++) begin
      case ($urandom_range(0, 4))
        0: step();
        1: begin reti = 1'b1; ibnd = 1'b0; step(); clear_bus(); end
        2: rd(ISTA_AD, ista(3'd1, 1'b0));
        3: wr_epc(16'($urandom));
        default: rd(EPC_AD, {3'b0, m_epc});
      endcase
    end
    ibnd = 1'b1; pc_cur = pc; flg_i = fl; reti = 1'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      v = 16'($urandom); we = 1'b1; addr = EPC_AD; din = v;
    end
    m_epc = pc; m_eflg = fl;
    step(); clear_bus();
    check("enter_redirect", redirect, 1);
    check("enter_stall", stall, 1);
    check("enter_int_rdy", int_rdy, 0);
  endtask

  task automatic to_isr();
    step();
    check("isr_in_isr", in_isr, 1);
    check("isr_stall", stall, 0);
    check("isr_int_rdy", int_rdy, 0);
  endtask

  task automatic do_isr(input int len);
    logic [DW-1:0] e;
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(0, 6))
        0: step();
        1: begin ibnd = 1'b1; step(); clear_bus(); end
        2: begin reti = 1'b1; step(); clear_bus(); end
        3: rd(ISTA_AD, ista(3'd3, 1'b1));
        4: rd(EPC_AD, {3'b0, m_epc});
        5: rd(13'($urandom_range(6, 4095)), 16'h0000);
        default: begin
          e = ista(3'd3, 1'b1);
          we = 1'b0; addr = ISTA_AD; rd_req = 1'b1; exp_rd.push_back(e);
          step();
          we = 1'b1; addr = EPC_AD; din = 16'($urandom); m_epc = din[AW-1:0];
          exp_rd.push_back(e);
          step(); clear_bus();
        end
      endcase
      check("isr_held", in_isr, 1);
    end
  endtask

  // ends in the IDLE cycle after the return redirect
  task automatic do_return(input logic same_wr);
    logic [DW-1:0] v;
    ibnd = 1'b1; reti = 1'b1;
    exp_redir.push_back('{pc: m_epc, fwe: 1'b1, fo: m_eflg});
    v = 16'($urandom);
    if (same_wr) begin
      we = 1'b1; addr = EPC_AD; din = v; m_epc = v[AW-1:0];
    end
    step(); clear_bus();
    check("ret_redirect", redirect, 1);
    check("ret_flg_we", flg_we, 1);
    check("ret_stall", stall, 1);
    check("ret_in_isr", in_isr, 1);
    check("ret_int_rdy", int_rdy, 0);
    step();
    check("post_ret_int_rdy", int_rdy, 1);
    check("post_ret_in_isr", in_isr, 0);
    check("post_ret_stall", stall, 0);
    if (same_wr && !int_vld) rd(EPC_AD, {3'b0, v[AW-1:0]});
  endtask

  initial begin
    repeat (3) step();
    check("rst_int_rdy", int_rdy, 0);
    check("rst_redirect", redirect, 0);
    check("rst_stall", stall, 0);
    check("rst_in_isr", in_isr, 0);
    check("rst_flg_we", flg_we, 0);
    check("rst_dout", dout, 0);
    rst = 1'b1;
    check("first_cycle_int_rdy", int_rdy, 0);
    step();
    check("idle_int_rdy", int_rdy, 1);
    rd(EPC_AD, 16'h0000);
    rd(ISTA_AD, 16'h0000);

    // stray reti outside ISR
    ibnd = 1'b1; reti = 1'b1;
    repeat (4) step();
    clear_bus();
    rd(ISTA_AD, 16'h0000);

    // EPC write drops upper bits
    wr_epc(16'hE123);
    rd(EPC_AD, 16'h0123);

    // basic entry and return
    do_entry(13'h0123, 4'hA, 0, 1'b0, 1'b1);
    to_isr();
    rd(ISTA_AD, 16'h00A7);
    do_isr(5);
    do_return(1'b0);

    // EPC override in ISR
    do_entry(13'h0777, 4'h3, 2, 1'b0, 1'b1);
    to_isr();
    wr_epc(16'h1FFF);
    rd(EPC_AD, 16'h1FFF);
    do_return(1'b0);

    // write coinciding with RETI boundary: old EPC is used
    do_entry(13'h0456, 4'h5, 1, 1'b0, 1'b1);
    to_isr();
    do_isr(3);
    do_return(1'b1);

    // delayed boundary
    do_entry(13'h0ABC, 4'hC, 50, 1'b0, 1'b1);
    to_isr();
    do_return(1'b0);

    // held request: no nesting, re-entry after return
    do_entry(13'h0321, 4'h9, 0, 1'b1, 1'b1);
    to_isr();
    do_isr(10);
    do_return(1'b0);
    do_entry(13'h0654, 4'h6, 2, 1'b0, 1'b1);
    to_isr();
    do_return(1'b0);

    for (int n = 0; n < 20; n++) begin
      do_entry(13'($urandom), 4'($urandom), $urandom_range(0, 6), 1'b0, 1'b1);
      to_isr();
      do_isr($urandom_range(0, 8));
      do_return(1'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end

    // asynchronous reset in the ENTER cycle
    do_entry(13'h0BEE, 4'hF, 0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    check("arst_redirect", redirect, 0);
    check("arst_stall", stall, 0);
    check("arst_int_rdy", int_rdy, 0);
    check("arst_in_isr", in_isr, 0);
    m_epc = '0; m_eflg = '0;
    step(); step();
    rst = 1'b1;
    check("arst_rel_int_rdy", int_rdy, 0);
    step();
    check("arst_idle_int_rdy", int_rdy, 1);
    rd(EPC_AD, 16'h0000);
    rd(ISTA_AD, 16'h0000);
    do_entry(13'h0111, 4'h2, 1, 1'b0, 1'b1);
    to_isr();
    do_return(1'b0);

    repeat (3) step();
    check("redir_queue_empty", exp_redir.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
